// File: rtl/mesh_port_arbiter.sv
// Round-robin output-port arbiter for a mesh router: packet-locked grants with a lock
// watchdog, feeding a single registered 64-bit flit link.
module mesh_port_arbiter #(
   parameter  int N_REQ        = 5,
   parameter  int FLIT_W       = 64,
   parameter  int LOCK_TIMEOUT = 16,
   localparam int ID_W         = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*FLIT_W-1:0] req_flit,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    out_valid,
   output logic [FLIT_W-1:0]       out_flit,
   input  logic                    out_ready,
   output logic [ID_W-1:0]         grant_id,
   output logic                    busy,
   output logic                    lock_abort
);

   localparam int WD_W = $clog2(LOCK_TIMEOUT);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t            state_r, state_n_s;
   logic [ID_W-1:0]   ptr_r, ptr_n_s;
   logic [ID_W-1:0]   lock_id_r, lock_id_n_s;
   logic [WD_W-1:0]   wd_cnt_r, wd_cnt_n_s;
   logic              abort_n_s;

   logic              space_s;
   logic              found_s;
   int                cand_s;
   logic [ID_W-1:0]   winner_s;
   logic [ID_W-1:0]   sel_id_s;
   logic [N_REQ-1:0]  req_ready_s;
   logic [FLIT_W-1:0] sel_flit_s;
   logic              xfer_s;
   logic              tail_s;

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      if (id == ID_W'(N_REQ - 1)) begin
         next_id = {ID_W{1'b0}};
      end else begin
         next_id = id + ID_W'(1);
      end
   endfunction

   // Rotating priority search starting at ptr
   always_comb begin
      found_s  = 1'b0;
      winner_s = ptr_r;
      cand_s   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_s = int'(ptr_r) + k;
         if (cand_s >= N_REQ) begin
            cand_s = cand_s - N_REQ;
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req_valid[cand_s]) begin
            found_s  = 1'b1;
            winner_s = ID_W'(cand_s);
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Grant selection and flit mux
   always_comb begin
      space_s     = ~out_valid | out_ready;
      req_ready_s = {N_REQ{1'b0}};
      sel_id_s    = winner_s;
      case (state_r)
         ST_IDLE: begin
            if (found_s && enable && space_s) begin
               req_ready_s[winner_s] = 1'b1;
            end else begin
               req_ready_s = {N_REQ{1'b0}};
            end
         end
         ST_LOCKED: begin
            sel_id_s               = lock_id_r;
            req_ready_s[lock_id_r] = req_valid[lock_id_r] & enable & space_s;
         end
         default: begin
            req_ready_s = {N_REQ{1'b0}};
         end
      endcase
      xfer_s     = |req_ready_s;
      sel_flit_s = {FLIT_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready_s[i]) begin
            sel_flit_s = req_flit[i*FLIT_W +: FLIT_W];
         end else begin
            sel_flit_s = sel_flit_s;
         end
      end
      tail_s = sel_flit_s[FLIT_W-1];
   end

   assign req_ready = req_ready_s;

   // Next-state: packet lock, pointer advance and watchdog
   always_comb begin
      state_n_s   = state_r;
      ptr_n_s     = ptr_r;
      lock_id_n_s = lock_id_r;
      wd_cnt_n_s  = wd_cnt_r;
      abort_n_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s && tail_s) begin
               ptr_n_s = next_id(winner_s);
            end else if (xfer_s) begin
               state_n_s   = ST_LOCKED;
               lock_id_n_s = winner_s;
               wd_cnt_n_s  = {WD_W{1'b0}};
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (xfer_s) begin
               wd_cnt_n_s = {WD_W{1'b0}};
               if (tail_s) begin
                  state_n_s = ST_IDLE;
                  ptr_n_s   = next_id(lock_id_r);
               end else begin
                  state_n_s = ST_LOCKED;
               end
            end else if (wd_cnt_r == WD_W'(LOCK_TIMEOUT - 1)) begin
               // Watchdog expiry counts every non-transfer cycle, whatever stalled it
               state_n_s  = ST_IDLE;
               ptr_n_s    = next_id(lock_id_r);
               abort_n_s  = 1'b1;
               wd_cnt_n_s = {WD_W{1'b0}};
            end else begin
               wd_cnt_n_s = wd_cnt_r + WD_W'(1);
            end
         end
         default: begin
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // FSM and arbitration state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         ptr_r     <= {ID_W{1'b0}};
         lock_id_r <= {ID_W{1'b0}};
         wd_cnt_r  <= {WD_W{1'b0}};
      end else begin
         state_r   <= state_n_s;
         ptr_r     <= ptr_n_s;
         lock_id_r <= lock_id_n_s;
         wd_cnt_r  <= wd_cnt_n_s;
      end
   end

   // Registered output flit and status
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_flit   <= {FLIT_W{1'b0}};
         grant_id   <= {ID_W{1'b0}};
         busy       <= 1'b0;
         lock_abort <= 1'b0;
      end else begin
         if (xfer_s) begin
            out_valid <= 1'b1;
            out_flit  <= sel_flit_s;
            grant_id  <= sel_id_s;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         busy       <= (state_n_s == ST_LOCKED);
         lock_abort <= abort_n_s;
      end
   end

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Randomized bench for mesh_port_arbiter, checked cycle by cycle against a
// packet-level round-robin reference model.
module tb_mesh_port_arbiter;

   localparam int N   = 5;
   localparam int FW  = 64;
   localparam int TO  = 16;
   localparam int IDW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [N-1:0]    req_valid;
   logic [N*FW-1:0] req_flit;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [FW-1:0]   out_flit;
   logic            out_ready;
   logic [IDW-1:0]  grant_id;
   logic            busy;
   logic            lock_abort;

   always #5 clk = ~clk;

   mesh_port_arbiter #(.N_REQ(N), .FLIT_W(FW), .LOCK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .req_valid(req_valid), .req_flit(req_flit), .req_ready(req_ready),
      .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
      .grant_id(grant_id), .busy(busy), .lock_abort(lock_abort)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // reference model state
   bit            m_locked;
   int            m_lock_id, m_ptr, m_wd, m_gid;
   bit            m_ov, m_abort;
   logic [FW-1:0] m_of;

   logic [FW-1:0] flits [N];
   int            seq = 0;
   int            p_valid, p_tail, p_ordy, p_en, p_rst;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r;
      r = '0;
      if (enable && (!m_ov || out_ready)) begin
         if (m_locked) begin
            if (req_valid[m_lock_id]) r[m_lock_id] = 1'b1;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (r == '0 && req_valid[(m_ptr + k) % N]) r[(m_ptr + k) % N] = 1'b1;
            end
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_lock_id = 0; m_ptr = 0; m_wd = 0; m_gid = 0;
      m_ov = 0; m_abort = 0; m_of = '0;
   endtask

   task automatic model_step(input logic [N-1:0] rdy);
      int w;
      bit tail;
      if (rst) begin
         model_reset();
         return;
      end
      w = -1;
      for (int i = 0; i < N; i++) if (rdy[i]) w = i;
      m_abort = 0;
      if (w >= 0) begin
         tail  = flits[w][FW-1];
         m_ov  = 1; m_of = flits[w]; m_gid = w;
         if (!m_locked) begin
            if (tail) m_ptr = (w + 1) % N;
            else begin m_locked = 1; m_lock_id = w; m_wd = 0; end
         end else begin
            m_wd = 0;
            if (tail) begin m_locked = 0; m_ptr = (m_lock_id + 1) % N; end
         end
      end else begin
         if (out_ready) m_ov = 0;
         if (m_locked) begin
            if (m_wd == TO - 1) begin
               m_locked = 0; m_ptr = (m_lock_id + 1) % N; m_abort = 1; m_wd = 0;
            end else m_wd++;
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("out_valid", 64'(out_valid), 64'(m_ov));
      check_eq("out_flit", out_flit, m_of);
      check_eq("grant_id", 64'(grant_id), 64'(m_gid));
      check_eq("busy", 64'(busy), 64'(m_locked));
      check_eq("lock_abort", 64'(lock_abort), 64'(m_abort));
   endtask

   task automatic run_cycle();
      logic [N-1:0] exp_rdy;
      logic [N-1:0] seen;
      @(negedge clk);
      cyc++;
      rst       = ($urandom_range(999) < p_rst);
      enable    = ($urandom_range(99) < p_en);
      out_ready = ($urandom_range(99) < p_ordy);
      for (int i = 0; i < N; i++) begin
         if (!req_valid[i] && $urandom_range(99) < p_valid) begin
            seq++;
            flits[i] = {($urandom_range(99) < p_tail), 7'd0, 8'(i), 48'(seq)};
            req_valid[i] = 1'b1;
            req_flit[i*FW +: FW] = flits[i];
         end
      end
      #1;
      exp_rdy = model_ready();
      seen    = req_ready;
      check_eq("req_ready", 64'(seen), 64'(exp_rdy));
      @(posedge clk);
      model_step(exp_rdy);
      #1;
      check_outputs();
      if (!rst) req_valid = req_valid & ~(seen & req_valid);
   endtask

   task automatic run_phase(input int n, input int pv, input int pt, input int po,
                            input int pe, input int pr);
      p_valid = pv; p_tail = pt; p_ordy = po; p_en = pe; p_rst = pr;
      for (int c = 0; c < n; c++) run_cycle();
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
      req_valid = '0; req_flit = '0;
      for (int i = 0; i < N; i++) flits[i] = '0;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      check_outputs();
      check_eq("reset_req_ready", 64'(req_ready), 64'(0));
      // all requesters streaming single-flit packets: strict rotation
      run_phase(30, 100, 100, 100, 100, 0);
      // mixed multi-flit packets with backpressure
      run_phase(1500, 40, 35, 70, 95, 0);
      // sparse requesters: locks frequently starve and the watchdog fires
      run_phase(1500, 4, 15, 80, 100, 0);
      // heavy load with enable toggling and output stalls
      run_phase(800, 90, 30, 50, 40, 0);
      // occasional reset mid-traffic
      run_phase(1500, 50, 30, 75, 90, 15);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
